// File: rtl/wb_pc_update.sv
// Write-back and PC-update stage of a sequential Y86-64 core: register file,
// program counter, sticky status and committed-instruction counter.
module wb_pc_update #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rdA,
    output logic [63:0] rdB,
    output logic [63:0] PC,
    output logic [1:0]  stat,
    output logic [63:0] retired
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;
    localparam logic [1:0] ST_INS = 2'd3;

    logic [63:0] regs [0:14];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  new_stat;
    logic [63:0] new_pc;
    logic        commit;

    always_comb begin
        dst_e = R_NONE;
        case (icode)
            I_IRMOVQ, I_OPQ:                 dst_e = rB;
            I_CMOV:                          dst_e = cnd ? rB : R_NONE;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:  dst_e = R_RSP;
            default:                         dst_e = R_NONE;
        endcase
    end

    always_comb begin
        dst_m = R_NONE;
        if (icode == I_MRMOVQ || icode == I_POPQ)
            dst_m = rA;
    end

    always_comb begin
        new_stat = ST_AOK;
        if (imem_error)
            new_stat = ST_ADR;
        else if (!instr_valid)
            new_stat = ST_INS;
        else if (dmem_error)
            new_stat = ST_ADR;
        else if (icode == I_HALT)
            new_stat = ST_HLT;
    end

    always_comb begin
        new_pc = valP;
        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   new_pc = cnd ? valC : valP;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

    assign commit = (stat == ST_AOK) && (new_stat == ST_AOK);

    // dstM is checked first so popq %rsp keeps the loaded value, not the ALU result.
    for (genvar g = 0; g < 15; g++) begin : g_reg
        always_ff @(posedge Clk) begin
            if (Reset)
                regs[g] <= '0;
            else if (commit) begin
                if (dst_m == 4'(g))
                    regs[g] <= valM;
                else if (dst_e == 4'(g))
                    regs[g] <= valE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC      <= RESET_PC;
            stat    <= ST_AOK;
            retired <= '0;
        end else if (stat == ST_AOK) begin
            if (new_stat != ST_AOK)
                stat <= new_stat;
            else begin
                PC      <= new_pc;
                retired <= retired + 64'd1;
            end
        end
    end

    // Reads see pre-edge contents; index 15 has no storage and reads as zero.
    always_comb begin
        rdA = '0;
        rdB = '0;
        for (int i = 0; i < 15; i++) begin
            if (srcA == 4'(i))
                rdA = regs[i];
            if (srcB == 4'(i))
                rdB = regs[i];
        end
    end

endmodule

// File: tb/tb_wb_pc_update.sv
// Bench for wb_pc_update: vector table with hand-computed expectations fed
// through a scoreboard queue, plus a read-before-write sequence.
module tb_wb_pc_update;

    localparam logic [63:0] RPC = 64'h1000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic        cnd, instr_valid, imem_error, dmem_error;
    logic [63:0] valC, valP, valE, valM;
    logic [63:0] rdA, rdB, PC, retired;
    logic [1:0]  stat;

    int checks = 0;
    int errors = 0;

    wb_pc_update #(.RESET_PC(RPC)) dut (
        .Clk(Clk), .Reset(Reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valC(valC), .valP(valP), .valE(valE), .valM(valM),
        .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
        .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB), .PC(PC), .stat(stat),
        .retired(retired)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ic, ra, rb;
        logic        cn;
        logic [63:0] vc, vp, ve, vm;
        logic        iv, ime, dme;
        logic [3:0]  chk;
        logic [63:0] exp_rd, exp_pc;
        logic [1:0]  exp_stat;
        logic [63:0] exp_ret;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  chk;
        logic [63:0] rd, pc;
        logic [1:0]  st;
        logic [63:0] ret;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] ic, ra, rb, input logic cn,
                       input logic [63:0] vc, vp, ve, vm, input logic iv, ime, dme,
                       input logic [3:0] chk, input logic [63:0] erd, epc,
                       input logic [1:0] est, input logic [63:0] eret);
        vec_t v;
        v.rst = rst; v.ic = ic; v.ra = ra; v.rb = rb; v.cn = cn;
        v.vc = vc; v.vp = vp; v.ve = ve; v.vm = vm;
        v.iv = iv; v.ime = ime; v.dme = dme;
        v.chk = chk; v.exp_rd = erd; v.exp_pc = epc; v.exp_stat = est; v.exp_ret = eret;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        Reset = v.rst; icode = v.ic; rA = v.ra; rB = v.rb; cnd = v.cn;
        valC = v.vc; valP = v.vp; valE = v.ve; valM = v.vm;
        instr_valid = v.iv; imem_error = v.ime; dmem_error = v.dme;
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        srcA = e.chk;
        #1;
        check($sformatf("v%0d_rd_r%0h", e.idx, e.chk), rdA, e.rd);
        check($sformatf("v%0d_pc", e.idx), PC, e.pc);
        check($sformatf("v%0d_stat", e.idx), 64'(stat), 64'(e.st));
        check($sformatf("v%0d_retired", e.idx), retired, e.ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst ic    ra    rb    cn vc      vp      ve                 vm       iv ime dme  chk   rd                 pc      st  ret
        add(0, 4'h3, 4'hF, 4'h2, 0, 64'h0,  64'd10, 64'd10,            64'h0,    1, 0, 0, 4'h2, 64'd10,            64'd10, 0, 1);
        add(0, 4'h7, 4'hF, 4'hF, 0, 64'h40, 64'd9,  64'h123,           64'h0,    1, 0, 0, 4'h2, 64'd10,            64'd9,  0, 2);
        add(0, 4'h7, 4'hF, 4'hF, 1, 64'h40, 64'd9,  64'h123,           64'h0,    1, 0, 0, 4'h2, 64'd10,            64'h40, 0, 3);
        add(0, 4'h3, 4'hF, 4'h4, 0, 64'h0,  64'h4a, 64'h100,           64'h0,    1, 0, 0, 4'h4, 64'h100,           64'h4a, 0, 4);
        add(0, 4'hB, 4'h4, 4'hF, 0, 64'h0,  64'h4c, 64'h108,           64'h55,   1, 0, 0, 4'h4, 64'h55,            64'h4c, 0, 5);
        add(0, 4'h8, 4'hF, 4'hF, 0, 64'h80, 64'h55, 64'hF8,            64'h0,    1, 0, 0, 4'h4, 64'hF8,            64'h80, 0, 6);
        add(0, 4'h9, 4'hF, 4'hF, 0, 64'h0,  64'h81, 64'h100,           64'h13,   1, 0, 0, 4'h4, 64'h100,           64'h13, 0, 7);
        add(0, 4'h2, 4'h2, 4'h3, 0, 64'h0,  64'h15, 64'h77,            64'h0,    1, 0, 0, 4'h3, 64'h0,             64'h15, 0, 8);
        add(0, 4'h2, 4'h2, 4'h3, 1, 64'h0,  64'h17, 64'h77,            64'h0,    1, 0, 0, 4'h3, 64'h77,            64'h17, 0, 9);
        add(0, 4'h6, 4'h1, 4'h5, 0, 64'h0,  64'h19, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 0, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h19, 0, 10);
        add(0, 4'h5, 4'h6, 4'h1, 0, 64'h0,  64'h23, 64'h999,           64'hABCD, 1, 0, 0, 4'h6, 64'hABCD,          64'h23, 0, 11);
        add(0, 4'h1, 4'h2, 4'h2, 1, 64'h0,  64'h25, 64'h555,           64'h777,  1, 0, 0, 4'h1, 64'h0,             64'h25, 0, 12);
        add(0, 4'h4, 4'h2, 4'h3, 1, 64'h0,  64'h2f, 64'h999,           64'h888,  1, 0, 0, 4'h3, 64'h77,            64'h2f, 0, 13);
        add(0, 4'hA, 4'h2, 4'h4, 0, 64'h0,  64'h31, 64'hF0,            64'h0,    1, 0, 0, 4'h4, 64'hF0,            64'h31, 0, 14);
        add(0, 4'h3, 4'hF, 4'hF, 0, 64'h0,  64'h3b, 64'h1,             64'h0,    1, 0, 0, 4'hF, 64'h0,             64'h3b, 0, 15);
        add(0, 4'h6, 4'hF, 4'h3, 0, 64'h0,  64'h3d, 64'h999,           64'h0,    0, 0, 1, 4'h3, 64'h77,            64'h3b, 3, 15);
        add(0, 4'h0, 4'hF, 4'hF, 0, 64'h0,  64'h50, 64'h0,             64'h0,    1, 0, 0, 4'h3, 64'h77,            64'h3b, 3, 15);
        add(0, 4'h3, 4'hF, 4'h3, 0, 64'h0,  64'h60, 64'h1,             64'h0,    1, 0, 0, 4'h3, 64'h77,            64'h3b, 3, 15);
        add(1, 4'h3, 4'hF, 4'h7, 0, 64'h0,  64'h70, 64'h3,             64'h0,    1, 0, 0, 4'h7, 64'h0,             RPC,    0, 0);
        add(0, 4'h3, 4'hF, 4'h7, 0, 64'h0,  64'h20, 64'h5,             64'h0,    0, 1, 0, 4'h7, 64'h0,             RPC,    2, 0);
        add(1, 4'h1, 4'hF, 4'hF, 0, 64'h0,  64'h0,  64'h0,             64'h0,    1, 0, 0, 4'h7, 64'h0,             RPC,    0, 0);
        add(0, 4'h1, 4'hF, 4'hF, 0, 64'h0,  64'h2,  64'h0,             64'h0,    1, 0, 1, 4'h7, 64'h0,             RPC,    2, 0);
        add(1, 4'h1, 4'hF, 4'hF, 0, 64'h0,  64'h0,  64'h0,             64'h0,    1, 0, 0, 4'h1, 64'h0,             RPC,    0, 0);
        add(0, 4'h3, 4'hF, 4'h1, 0, 64'h0,  64'h20, 64'h5,             64'h0,    1, 0, 0, 4'h1, 64'h5,             64'h20, 0, 1);
        add(0, 4'h0, 4'hF, 4'hF, 0, 64'h0,  64'h22, 64'h0,             64'h0,    1, 0, 0, 4'h1, 64'h5,             64'h20, 1, 1);
        add(0, 4'h3, 4'hF, 4'h1, 0, 64'h0,  64'h30, 64'h9,             64'h0,    1, 0, 0, 4'h1, 64'h5,             64'h20, 1, 1);
        add(1, 4'h3, 4'hF, 4'h1, 0, 64'h0,  64'h30, 64'h9,             64'h0,    1, 0, 0, 4'h1, 64'h0,             RPC,    0, 0);

        Reset = 1'b1; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valC = '0; valP = '0; valE = '0; valM = '0;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
        srcA = 4'h0; srcB = 4'hF;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_pc", PC, RPC);
        check("reset_stat", 64'(stat), 64'd0);
        check("reset_retired", retired, 64'd0);
        check("reset_rdB_none", rdB, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge Clk);
            drive(vecs[i]);
            e.idx = i; e.chk = vecs[i].chk; e.rd = vecs[i].exp_rd;
            e.pc = vecs[i].exp_pc; e.st = vecs[i].exp_stat; e.ret = vecs[i].exp_ret;
            sb.push_back(e);
            @(posedge Clk);
            #1;
            compare_next();
        end

        // Write lands only at the committing edge, never combinationally.
        @(negedge Clk);
        Reset = 1'b0; icode = 4'h3; rA = 4'hF; rB = 4'h8; cnd = 1'b0;
        valE = 64'h66; valP = 64'h8; valM = 64'h0; valC = 64'h0;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
        srcB = 4'h8;
        #1;
        check("wt_pre_edge_rdB", rdB, 64'h0);
        @(posedge Clk);
        #1;
        check("wt_post_edge_rdB", rdB, 64'h66);
        check("wt_pc", PC, 64'h8);
        check("wt_retired", retired, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
